sig_phase_scheduler: RTL and testbench
======================================

# sig_phase_scheduler

Timed phase scheduler for the highway/country-road intersection. It sequences the two signal heads through green, yellow and all-red phases using programmable dwell counters. It arbitrates between the country-road sensor, a latched pedestrian request and an emergency pre-emption input. It is the top-level sequencing block that owns the `hwy`/`cntry` light encodings driven to the intersection.

## Interface
- `HWY_MIN_GREEN`, 8: minimum highway-green dwell, cycles (≥1)
- `CNTRY_MAX_GREEN`, 6: maximum country-green dwell, cycles (≥1)
- `YELLOW_CYCLES`, 3: yellow dwell, both roads (≥1)
- `ALLRED_CYCLES`, 2: all-red clearance dwell (≥1)
- `WALK_CYCLES`, 5: pedestrian walk dwell (≥1)
- `CNT_W`, 8: dwell counter width; every dwell parameter must be ≤ 2^CNT_W
- `clock`  in  1  system clock, rising edge
- `clear`  in  1  asynchronous, active-low reset
- `x`  in  1  country-road vehicle sensor, level, synchronous to `clock`
- `ped_req`  in  1  pedestrian request, pulse or level
- `emerg`  in  1  emergency pre-emption (highway priority), level
- `hwy`  out  2  highway head: 0=RED, 1=YELLOW, 2=GREEN (3 never driven)
- `cntry`  out  2  country head, same encoding
- `walk`  out  1  pedestrian walk lamp
- `phase`  out  3  current state code, for debug/verification

## Operation
- States and codes: HG=0 (hwy G, cntry R), HY=1 (hwy Y, cntry R), AR1=2 (all red), CG=3 (hwy R, cntry G), CY=4 (hwy R, cntry Y), AR2=5 (all red), WALK=6 (all red, walk=1). Code 7 is illegal and recovers to HG on the next edge.
- Dwell counter `cnt`: loaded with (dwell − 1) on every state entry and decremented each cycle while >0. "Expired" means cnt==0.
- HG: leave to HY when expired AND emerg=0 AND (x=1 OR ped_pending=1). Otherwise hold indefinitely.
- HY: expired → AR1.
- AR1: expired → HG if emerg=1; else WALK if ped_pending=1; else CG.
- CG: → CY when emerg=1, x=0, or expired, evaluated every cycle including the first cycle of CG.
- CY: expired → AR2. AR2: expired → HG. WALK: expired → AR2. Emergency does not truncate HY, AR1, CY, AR2 or WALK.
- ped_pending: sticky bit. Set by ped_req=1 in any state except WALK. Cleared on the edge that enters WALK; a ped_req on that same cycle is dropped. Requests arriving during WALK are ignored.
- Outputs `hwy`, `cntry`, `walk` and `phase` are registered and updated on the same edge as the state, so they are a Moore decode of the next state.

## Timing
- Reset (clear=0, asynchronous): state=HG, cnt=HWY_MIN_GREEN−1, hwy=2, cntry=0, walk=0, phase=0, ped_pending=0. Outputs take these values immediately, without a clock edge.
- First active edge after clear rises: HG counting from HWY_MIN_GREEN−1.
- A state entered at edge k with dwell N and its exit condition true exits at edge k+N. Outputs therefore show exactly N cycles of that phase.
- Input-to-output latency is one edge: x, emerg and ped_req are sampled at edge k, and the resulting phase change is visible after edge k.
- Reset asserted mid-phase: immediate return to the reset values, and pending requests are lost.
- Safety invariant: hwy≠0 and cntry≠0 never hold simultaneously. Every transition between the two greens passes through yellow and then all-red for the full parameter dwell.

## Test plan
- x=0, ped_req=0, emerg=0 for 100 cycles after reset: hwy=2, cntry=0, walk=0 throughout; phase=0.
- x=1 held from reset release (defaults): HG 8 cycles, HY 3, AR1 2, CG 6 (max-green cap), CY 3, AR2 2, HG 8, then the sequence repeats. Phase trace is 0,1,2,3,4,5,0 with those exact dwells.
- x=1 from reset release, then x=0 on the 2nd cycle of CG: CG lasts exactly 2 cycles, then CY 3, AR2 2, HG.
- Single-cycle ped_req at cycle 3, x=0: HG 8, HY 3, AR1 2, WALK 5 with walk=1, AR2 2, HG. A second ped_req pulsed during WALK produces no further walk cycle.
- x=1 with emerg raised on the 3rd CG cycle: CY on the next edge. With emerg held high, the controller stays in HG indefinitely despite x=1 and a pending ped_req. When emerg drops, HY begins on the next edge, followed by AR1 and WALK.
- clear driven low mid-CY: hwy=2, cntry=0, walk=0, phase=0 asynchronously. After clear rises, HG dwells the full 8 cycles before any exit.

Source files
------------

// File: rtl/sig_phase_scheduler.sv
// Highway/country-road phase scheduler: sequences both signal heads through green,
// yellow and all-red dwells and arbitrates the country sensor, pedestrian and emergency.
module sig_phase_scheduler #(
   parameter int HWY_MIN_GREEN   = 8,
   parameter int CNTRY_MAX_GREEN = 6,
   parameter int YELLOW_CYCLES   = 3,
   parameter int ALLRED_CYCLES   = 2,
   parameter int WALK_CYCLES     = 5,
   parameter int CNT_W           = 8
) (
   input  logic       clock,
   input  logic       clear,
   input  logic       x,
   input  logic       ped_req,
   input  logic       emerg,
   output logic [1:0] hwy,
   output logic [1:0] cntry,
   output logic       walk,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      S_HG   = 3'd0,
      S_HY   = 3'd1,
      S_AR1  = 3'd2,
      S_CG   = 3'd3,
      S_CY   = 3'd4,
      S_AR2  = 3'd5,
      S_WALK = 3'd6
   } state_t;

   localparam logic [1:0] RED = 2'd0;
   localparam logic [1:0] YEL = 2'd1;
   localparam logic [1:0] GRN = 2'd2;

   state_t            state;
   state_t            state_next;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_next;
   logic              ped_pending;
   logic              ped_next;
   logic              expired;

   function automatic logic [CNT_W-1:0] dwell_load(input state_t s);
      case (s)
         S_HG:         dwell_load = CNT_W'(HWY_MIN_GREEN - 1);
         S_HY, S_CY:   dwell_load = CNT_W'(YELLOW_CYCLES - 1);
         S_AR1, S_AR2: dwell_load = CNT_W'(ALLRED_CYCLES - 1);
         S_CG:         dwell_load = CNT_W'(CNTRY_MAX_GREEN - 1);
         S_WALK:       dwell_load = CNT_W'(WALK_CYCLES - 1);
         default:      dwell_load = CNT_W'(HWY_MIN_GREEN - 1);
      endcase
   endfunction

   function automatic logic [1:0] hwy_of(input state_t s);
      case (s)
         S_HG:    hwy_of = GRN;
         S_HY:    hwy_of = YEL;
         default: hwy_of = RED;
      endcase
   endfunction

   function automatic logic [1:0] cntry_of(input state_t s);
      case (s)
         S_CG:    cntry_of = GRN;
         S_CY:    cntry_of = YEL;
         default: cntry_of = RED;
      endcase
   endfunction

   assign expired = (cnt == '0);

   always_comb begin
      state_next = state;
      case (state)
         S_HG:   if (expired && !emerg && (x || ped_pending)) state_next = S_HY;
         S_HY:   if (expired) state_next = S_AR1;
         S_AR1: begin
            if (expired) begin
               if (emerg)            state_next = S_HG;
               else if (ped_pending) state_next = S_WALK;
               else                  state_next = S_CG;
            end
         end
         // Country green yields immediately, even on its first cycle.
         S_CG:   if (emerg || !x || expired) state_next = S_CY;
         S_CY:   if (expired) state_next = S_AR2;
         S_AR2:  if (expired) state_next = S_HG;
         S_WALK: if (expired) state_next = S_AR2;
         default: state_next = S_HG;
      endcase
   end

   always_comb begin
      cnt_next = cnt;
      if (state_next != state) cnt_next = dwell_load(state_next);
      else if (!expired)       cnt_next = cnt - CNT_W'(1);
   end

   // Entering WALK consumes the request; a same-cycle request is dropped.
   always_comb begin
      ped_next = ped_pending;
      if (state_next == S_WALK && state != S_WALK) ped_next = 1'b0;
      else if (ped_req && state != S_WALK)         ped_next = 1'b1;
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state       <= S_HG;
         cnt         <= CNT_W'(HWY_MIN_GREEN - 1);
         ped_pending <= 1'b0;
         hwy         <= GRN;
         cntry       <= RED;
         walk        <= 1'b0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         ped_pending <= ped_next;
         hwy         <= hwy_of(state_next);
         cntry       <= cntry_of(state_next);
         walk        <= (state_next == S_WALK);
      end
   end

   assign phase = state;

endmodule

// File: tb/tb_sig_phase_scheduler.sv
// Directed bench for sig_phase_scheduler: walks each phase sequence with hand-counted dwells.
module tb_sig_phase_scheduler;

   logic       clock;
   logic       clear;
   logic       x;
   logic       ped_req;
   logic       emerg;
   logic [1:0] hwy;
   logic [1:0] cntry;
   logic       walk;
   logic [2:0] phase;

   int vectors    = 0;
   int miscompares = 0;

   sig_phase_scheduler dut (
      .clock   (clock),
      .clear   (clear),
      .x       (x),
      .ped_req (ped_req),
      .emerg   (emerg),
      .hwy     (hwy),
      .cntry   (cntry),
      .walk    (walk),
      .phase   (phase)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish within time budget");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [2:0] exp_phase);
      logic [1:0] eh;
      logic [1:0] ec;
      logic       ew;
      eh = 2'd0;
      ec = 2'd0;
      ew = 1'b0;
      case (exp_phase)
         3'd0: eh = 2'd2;
         3'd1: eh = 2'd1;
         3'd3: ec = 2'd2;
         3'd4: ec = 2'd1;
         3'd6: ew = 1'b1;
         default: ;
      endcase
      vectors++;
      assert (phase === exp_phase) else begin
         miscompares++;
         $error("FAIL %s phase observed %0d expected %0d", tag, phase, exp_phase);
      end
      vectors++;
      assert (hwy === eh) else begin
         miscompares++;
         $error("FAIL %s hwy observed %0d expected %0d", tag, hwy, eh);
      end
      vectors++;
      assert (cntry === ec) else begin
         miscompares++;
         $error("FAIL %s cntry observed %0d expected %0d", tag, cntry, ec);
      end
      vectors++;
      assert (walk === ew) else begin
         miscompares++;
         $error("FAIL %s walk observed %0d expected %0d", tag, walk, ew);
      end
      vectors++;
      assert (!(hwy != 2'd0 && cntry != 2'd0)) else begin
         miscompares++;
         $error("FAIL %s safety observed hwy=%0d cntry=%0d expected one red", tag, hwy, cntry);
      end
   endtask

   task automatic run(input string tag, input logic [2:0] ph, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         chk(tag, ph);
      end
   endtask

   // Leaves the bench at the release negedge, which is HG cycle 1.
   task automatic apply_reset(input logic xv);
      @(negedge clock);
      clear   = 1'b0;
      x       = xv;
      ped_req = 1'b0;
      emerg   = 1'b0;
      #1 chk("rst_async", 3'd0);
      @(negedge clock);
      chk("rst_hold", 3'd0);
      clear = 1'b1;
      chk("rel", 3'd0);
   endtask

   initial begin
      clear   = 1'b1;
      x       = 1'b0;
      ped_req = 1'b0;
      emerg   = 1'b0;
      #2 clear = 1'b0;
      #1 chk("pwr_reset", 3'd0);

      // idle: no demand, highway green forever
      @(negedge clock);
      clear = 1'b1;
      chk("idle_rel", 3'd0);
      run("idle", 3'd0, 100);

      // continuous country demand, full cycle with max-green cap
      apply_reset(1'b1);
      run("cyc_hg", 3'd0, 7);
      run("cyc_hy", 3'd1, 3);
      run("cyc_ar1", 3'd2, 2);
      run("cyc_cg", 3'd3, 6);
      run("cyc_cy", 3'd4, 3);
      run("cyc_ar2", 3'd5, 2);
      run("cyc_hg2", 3'd0, 8);
      run("cyc_hy2", 3'd1, 1);

      // country car leaves on 2nd CG cycle
      apply_reset(1'b1);
      run("gap_hg", 3'd0, 7);
      run("gap_hy", 3'd1, 3);
      run("gap_ar1", 3'd2, 2);
      run("gap_cg", 3'd3, 2);
      x = 1'b0;
      run("gap_cy", 3'd4, 3);
      run("gap_ar2", 3'd5, 2);
      run("gap_hg2", 3'd0, 10);

      // single pedestrian pulse at cycle 3, second pulse during WALK ignored
      apply_reset(1'b0);
      run("ped_hg", 3'd0, 2);
      ped_req = 1'b1;
      run("ped_hg", 3'd0, 1);
      ped_req = 1'b0;
      run("ped_hg", 3'd0, 4);
      run("ped_hy", 3'd1, 3);
      run("ped_ar1", 3'd2, 2);
      run("ped_walk", 3'd6, 1);
      ped_req = 1'b1;
      run("ped_walk", 3'd6, 1);
      ped_req = 1'b0;
      run("ped_walk", 3'd6, 3);
      run("ped_ar2", 3'd5, 2);
      run("ped_hg2", 3'd0, 12);

      // emergency truncates CG, then holds HG against demand
      apply_reset(1'b1);
      run("em_hg", 3'd0, 7);
      run("em_hy", 3'd1, 3);
      run("em_ar1", 3'd2, 2);
      run("em_cg", 3'd3, 3);
      emerg = 1'b1;
      run("em_cy", 3'd4, 1);
      ped_req = 1'b1;
      run("em_cy", 3'd4, 1);
      ped_req = 1'b0;
      run("em_cy", 3'd4, 1);
      run("em_ar2", 3'd5, 2);
      run("em_hold", 3'd0, 20);
      emerg = 1'b0;
      run("em_hy", 3'd1, 3);
      run("em_ar1b", 3'd2, 2);
      run("em_walk", 3'd6, 5);
      run("em_ar2b", 3'd5, 2);
      run("em_hg2", 3'd0, 8);
      run("em_hy2", 3'd1, 1);

      // clear mid-CY drops the pending request and restarts HG dwell
      apply_reset(1'b1);
      run("mid_hg", 3'd0, 7);
      run("mid_hy", 3'd1, 3);
      run("mid_ar1", 3'd2, 2);
      run("mid_cg", 3'd3, 6);
      run("mid_cy", 3'd4, 1);
      ped_req = 1'b1;
      run("mid_cy", 3'd4, 1);
      ped_req = 1'b0;
      #2 clear = 1'b0;
      #1 chk("mid_clr", 3'd0);
      @(negedge clock);
      clear = 1'b1;
      chk("mid_rel", 3'd0);
      run("mid_hg2", 3'd0, 7);
      run("mid_hy2", 3'd1, 3);
      run("mid_ar12", 3'd2, 2);
      run("mid_cg2", 3'd3, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
